// File: rtl/load_store_unit_if.sv
// Request, data-memory and write-back signals of the load/store unit.
// The unit uses the slave modport; the execute stage/memory side uses master.
interface load_store_unit_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic              req_load;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [4:0]        req_rd;
   logic [ADDR_W-3:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [31:0]       wb_data;
   logic              err;

   modport slave (
      input  req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
      output req_ready, mem_addr, mem_re, mem_we, mem_be, mem_wdata,
             wb_valid, wb_rd, wb_data, err
   );

   modport master (
      output req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd, mem_rdata,
      input  req_ready, mem_addr, mem_re, mem_we, mem_be, mem_wdata,
             wb_valid, wb_rd, wb_data, err
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: byte/half/word accesses become one or two aligned word
// accesses with byte enables; loads are realigned and extended for write-back.
module load_store_unit #(
   parameter int ADDR_W = 10
) (
   input logic               clk,
   input logic               rst,
   load_store_unit_if.slave  bus
);
   localparam int WW = ADDR_W - 2;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RDWAIT} state_e;

   state_e            state_q, state_d;
   logic              load_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, lo_q, wb_data_q;
   logic [4:0]        rd_q, wb_rd_q;
   logic              wb_valid_q, err_q;

   logic [1:0]  off;
   logic [2:0]  size;
   logic        split, illegal, accept;
   logic [7:0]  mask8;
   logic [63:0] data64, win;
   logic [31:0] hi_word, lo_word, ld_res;
   logic [WW-1:0] w0, w1;

   logic [WW-1:0] mem_addr;
   logic          mem_re, mem_we;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;

   assign off     = addr_q[1:0];
   assign size    = (f3_q[1:0] == 2'b00) ? 3'd1 : (f3_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
   assign split   = ({1'b0, off} + size) > 3'd4;
   assign mask8   = ((8'd1 << size) - 8'd1) << off;
   assign data64  = {32'b0, wdata_q} << {off, 3'b000};
   assign w0      = addr_q[ADDR_W-1:2];
   assign w1      = w0 + WW'(1);

   assign accept  = (state_q == IDLE) && bus.req_valid;
   assign illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                    (bus.req_funct3[2] && !bus.req_load);

   // Split loads arrive low word first (captured in ACC1), high word in RDWAIT.
   assign hi_word = split ? bus.mem_rdata : 32'b0;
   assign lo_word = split ? lo_q : bus.mem_rdata;
   assign win     = {hi_word, lo_word} >> {off, 3'b000};

   always_comb begin
      ld_res = win[31:0];
      case (f3_q[1:0])
         2'b00:   ld_res = f3_q[2] ? {24'b0, win[7:0]}  : {{24{win[7]}}, win[7:0]};
         2'b01:   ld_res = f3_q[2] ? {16'b0, win[15:0]} : {{16{win[15]}}, win[15:0]};
         default: ld_res = win[31:0];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      mem_addr  = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b0;
      mem_wdata = 32'b0;
      case (state_q)
         IDLE: if (accept && !illegal) state_d = ACC0;
         ACC0: begin
            mem_addr = w0;
            if (load_q) begin
               mem_re  = 1'b1;
               state_d = split ? ACC1 : RDWAIT;
            end else begin
               mem_we    = 1'b1;
               mem_be    = mask8[3:0];
               mem_wdata = data64[31:0];
               state_d   = split ? ACC1 : IDLE;
            end
         end
         ACC1: begin
            mem_addr = w1;
            if (load_q) begin
               mem_re  = 1'b1;
               state_d = RDWAIT;
            end else begin
               mem_we    = 1'b1;
               mem_be    = mask8[7:4];
               mem_wdata = data64[63:32];
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         load_q     <= 1'b0;
         f3_q       <= 3'b0;
         addr_q     <= '0;
         wdata_q    <= 32'b0;
         rd_q       <= 5'b0;
         lo_q       <= 32'b0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= 32'b0;
         wb_rd_q    <= 5'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= 1'b0;
         err_q      <= 1'b0;
         if (accept) begin
            load_q  <= bus.req_load;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rd_q    <= bus.req_rd;
            err_q   <= illegal;
         end
         if (state_q == ACC1) lo_q <= bus.mem_rdata;
         if (state_q == RDWAIT) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= ld_res;
            wb_rd_q    <= rd_q;
         end
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_re    = mem_re;
   assign bus.mem_we    = mem_we;
   assign bus.mem_be    = mem_be;
   assign bus.mem_wdata = mem_wdata;
   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_rd     = wb_rd_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a
// byte-addressed reference memory; a word memory model answers the DUT.
module tb_load_store_unit;
   localparam int ADDR_W = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();
   load_store_unit #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   logic [31:0] mem [256];
   logic [7:0]  ref_mem [1024];
   int n_chk = 0;
   int n_fail = 0;

   always @(posedge clk) begin
      if (bus.mem_we)
         for (int l = 0; l < 4; l++)
            if (bus.mem_be[l]) mem[bus.mem_addr][8*l +: 8] <= bus.mem_wdata[8*l +: 8];
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic do_req(input bit ld, input logic [2:0] f3, input logic [9:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input bit full,
                         output logic [31:0] got);
      int s, b, wi, cyc, nw;
      bit ill;
      logic [3:0]  ebe [2];
      logic [31:0] ewd [2];
      logic [31:0] v, lm;
      got = 32'b0;
      ill = (f3 == 3'd3) || (f3 >= 3'd6) || (f3[2] && !ld);
      s = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      ebe[0] = 4'h0; ebe[1] = 4'h0; ewd[0] = 32'h0; ewd[1] = 32'h0; v = 32'h0;
      for (int i = 0; i < s; i++) begin
         b  = (int'(a) + i) % 1024;
         wi = ((b >> 2) != (int'(a) >> 2)) ? 1 : 0;
         ebe[wi][b % 4] = 1'b1;
         ewd[wi][8*(b % 4) +: 8] = wd[8*i +: 8];
         v[8*i +: 8] = ref_mem[b];
         if (!ld && !ill) ref_mem[b] = wd[8*i +: 8];
      end
      if (s == 1) v = f3[2] ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      if (s == 2) v = f3[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      nw = (ebe[1] != 4'h0) ? 2 : 1;

      cyc = 0;
      while (!bus.req_ready && cyc < 20) begin @(negedge clk); cyc++; end
      check("ready_before_req", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1; bus.req_load = ld; bus.req_funct3 = f3;
      bus.req_addr = a; bus.req_wdata = wd; bus.req_rd = rd;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;

      if (ill) begin
         check("err_pulse", 32'(bus.err), 32'd1);
         check("err_no_strobe", 32'({bus.mem_we, bus.mem_re, bus.wb_valid}), 32'd0);
         check("err_ready", 32'(bus.req_ready), 32'd1);
         @(negedge clk);
         check("err_clears", 32'(bus.err), 32'd0);
         return;
      end
      check("no_err", 32'(bus.err), 32'd0);
      for (int k = 0; k < nw; k++) begin
         lm = {{8{ebe[k][3]}}, {8{ebe[k][2]}}, {8{ebe[k][1]}}, {8{ebe[k][0]}}};
         check("strobe_we", 32'(bus.mem_we), 32'(!ld));
         check("strobe_re", 32'(bus.mem_re), 32'(ld));
         check("strobe_addr", 32'(bus.mem_addr), 32'(((int'(a) >> 2) + k) % 256));
         check("strobe_be", 32'(bus.mem_be), ld ? 32'd0 : 32'(ebe[k]));
         if (!ld) check("strobe_wdata", full ? bus.mem_wdata : (bus.mem_wdata & lm), ewd[k]);
         check("busy_no_wb", 32'({bus.req_ready, bus.wb_valid}), 32'd0);
         @(negedge clk);
      end
      if (!ld) begin
         check("store_done", 32'({bus.req_ready, bus.mem_we, bus.wb_valid}), 32'b100);
         return;
      end
      check("rdwait", 32'({bus.req_ready, bus.mem_re, bus.wb_valid}), 32'b000);
      @(negedge clk);
      check("wb_valid", 32'({bus.req_ready, bus.wb_valid}), 32'b11);
      check("wb_data", bus.wb_data, v);
      check("wb_rd", 32'(bus.wb_rd), 32'(rd));
      got = bus.wb_data;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] got, rw;
      bit saw_wb;
      bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_funct3 = 3'b0;
      bus.req_addr = '0; bus.req_wdata = 32'b0; bus.req_rd = 5'b0;
      for (int w = 0; w < 256; w++) begin
         rw = $urandom;
         mem[w] = rw;
         for (int l = 0; l < 4; l++) ref_mem[4*w + l] = rw[8*l +: 8];
      end
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 32'd1);
      check("rst_strobes", 32'({bus.mem_we, bus.mem_re, bus.wb_valid, bus.err}), 32'd0);
      check("rst_bus", 32'(bus.mem_addr) | 32'(bus.mem_be) | bus.mem_wdata, 32'd0);
      check("rst_wb", bus.wb_data | 32'(bus.wb_rd), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      do_req(1'b0, 3'b010, 10'h010, 32'hDEADBEEF, 5'd0, 1'b1, got);
      do_req(1'b0, 3'b000, 10'h013, 32'h000000A5, 5'd0, 1'b1, got);
      do_req(1'b1, 3'b000, 10'h013, 32'h0, 5'd3, 1'b1, got);
      check("lb_literal", got, 32'hFFFFFFA5);
      do_req(1'b1, 3'b100, 10'h013, 32'h0, 5'd4, 1'b1, got);
      check("lbu_literal", got, 32'h000000A5);
      do_req(1'b0, 3'b010, 10'h022, 32'h11223344, 5'd0, 1'b1, got);
      do_req(1'b1, 3'b010, 10'h022, 32'h0, 5'd7, 1'b1, got);
      check("lw_split_literal", got, 32'h11223344);
      do_req(1'b0, 3'b000, 10'h3FF, 32'h00000080, 5'd0, 1'b1, got);
      do_req(1'b0, 3'b000, 10'h000, 32'h00000012, 5'd0, 1'b1, got);
      do_req(1'b1, 3'b101, 10'h3FF, 32'h0, 5'd9, 1'b1, got);
      check("lhu_wrap_literal", got, 32'h00001280);
      do_req(1'b1, 3'b001, 10'h3FF, 32'h0, 5'd9, 1'b1, got);
      check("lh_wrap_literal", got, 32'h00001280);
      do_req(1'b1, 3'b011, 10'h040, 32'h0, 5'd1, 1'b1, got);
      do_req(1'b0, 3'b100, 10'h040, 32'h12345678, 5'd1, 1'b1, got);

      // Reset in the second access of a split load must abandon it silently.
      while (!bus.req_ready) @(negedge clk);
      bus.req_valid = 1'b1; bus.req_load = 1'b1; bus.req_funct3 = 3'b010;
      bus.req_addr = 10'h022; bus.req_rd = 5'd5;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_mid_strobes", 32'({bus.mem_re, bus.mem_we, bus.wb_valid}), 32'd0);
      check("rst_mid_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      saw_wb = 1'b0;
      repeat (5) begin @(negedge clk); if (bus.wb_valid) saw_wb = 1'b1; end
      check("rst_no_wb_after", 32'(saw_wb), 32'd0);
      check("rst_ready_after", 32'(bus.req_ready), 32'd1);

      for (int t = 0; t < 120; t++)
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 10'($urandom),
                $urandom, 5'($urandom), 1'b0, got);

      for (int w = 0; w < 256; w++)
         check("mem_final", mem[w],
               {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the execute stage and the word-organised data memory. It accepts one load or store request per handshake and converts RV32 byte, halfword and word accesses (LB/LH/LW/LBU/LHU, SB/SH/SW) into aligned word accesses with byte enables. Accesses that cross a word boundary are split into two consecutive word accesses. For loads it returns sign- or zero-extended, byte-aligned data to write-back.

## Interface

Parameters:
- ADDR_W, 10, byte-address width; data memory holds 2^(ADDR_W-2) words.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_load  in  1  1 = load, 0 = store.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; bits [8·size-1:0] are used.
- req_rd  in  5  load destination register.
- mem_addr  out  ADDR_W-2  word index.
- mem_re  out  1  read strobe.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables for mem_we.
- mem_wdata  out  32  byte-lane-positioned write data.
- mem_rdata  in  32  read data; valid the cycle after mem_re (synchronous read).
- wb_valid  out  1  one-cycle pulse carrying a completed load.
- wb_rd  out  5  destination register for the load.
- wb_data  out  32  extended load result.
- err  out  1  one-cycle pulse for an illegal request.

## Operation

- States: IDLE, ACC0, ACC1, RDWAIT.
- Accept: req_valid && req_ready in IDLE. On accept, the unit captures load, funct3, addr, wdata and rd.
- Size s is 1, 2 or 4 bytes, from funct3[1:0]. Offset o = addr[1:0].
- Split: the request is split when o + s > 4.
- Word indices: w0 = addr[ADDR_W-1:2]; w1 = w0 + 1, modulo 2^(ADDR_W-2), so the last word wraps to word 0.
- 8-byte window:
  - Enable mask = ((1<<s)-1) << o.
  - Data = {32'b0, wdata} << 8·o.
  - The low half goes to w0 and the high half to w1.
- Illegal requests: funct3 011, 110 or 111; funct3 100 or 101 with req_load = 0.
  - err pulses in the cycle after accept.
  - No memory strobe and no wb_valid.
  - State stays IDLE.
- IDLE -> ACC0 on a legal accept.
- ACC0:
  - Drives mem_addr = w0.
  - Store: mem_we = 1, mem_be = low mask. Next state is ACC1 if split, else IDLE.
  - Load: mem_re = 1. Next state is ACC1 if split, else RDWAIT.
- ACC1:
  - Drives mem_addr = w1.
  - Store: mem_we = 1, mem_be = high mask, then IDLE.
  - Load: mem_re = 1, captures mem_rdata as the low word, then RDWAIT.
- RDWAIT:
  - Captures mem_rdata, as the high word if split, else as the low word.
  - Forms ({hi, lo} >> 8·o), truncates to s bytes, and sign-extends (funct3[2] = 0) or zero-extends.
  - Registers the result to wb_data and wb_rd, pulses wb_valid, then IDLE.
- mem_be, mem_wdata and mem_addr are 0 whenever no strobe is active.
- Stores never assert wb_valid.

## Timing

- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - req_ready = 1; all other outputs are 0.
  - Any in-flight access is abandoned with no wb_valid.
- Latencies from the accept cycle T:
  - Non-split store: mem_we in T+1; req_ready high again at T+2.
  - Split store: mem_we in T+1 (w0) and T+2 (w1); ready at T+3.
  - Non-split load: mem_re in T+1; wb_valid in T+3; ready at T+3.
  - Split load: mem_re in T+1 and T+2; wb_valid in T+4; ready at T+4.
  - Illegal request: err in T+1; ready at T+1.
- req_ready is combinational on state (== IDLE). Requests presented while it is low are ignored and must be held by the sender.
- A new request accepted in the wb_valid cycle is legal. Its first strobe follows in the next cycle.

## Test plan

- SW addr 0x010, data 0xDEADBEEF -> T+1: mem_we = 1, mem_addr = 4, be = 1111, wdata = 0xDEADBEEF; no wb_valid.
- SB addr 0x013, data 0x000000A5 -> T+1: be = 1000, wdata = 0xA5000000. Then LB addr 0x013 -> wb_data = 0xFFFFFFA5. Then LBU -> wb_data = 0x000000A5.
- Misaligned SW addr 0x022, data 0x11223344:
  - T+1: addr 8, be = 1100, wdata = 0x33440000.
  - T+2: addr 9, be = 0011, wdata = 0x00001122.
  - Then LW addr 0x022 -> two reads; wb_data = 0x11223344 at T+4.
- Wrap: LH addr 0x3FF with word 255 = 0x80xxxxxx and word 0 = 0xxxxxxx12 -> reads at word 255 then word 0; wb_data = 0x00001280.
- Illegal funct3 011 load -> err pulse at T+1, no strobes, ready at T+1. Store with funct3 100 -> same response.
- Reset asserted during ACC1 of a split load -> outputs 0 immediately; no wb_valid after release; req_ready = 1.
